// File: rtl/alu_mul_seq_pkg.sv
// alu_mul_seq_pkg: shared ALU opcodes, comparison types and multiplier FSM states
package alu_mul_seq_pkg;
  localparam logic [3:0] ALU_NOP = 4'h0;
  localparam logic [3:0] ALU_ADD = 4'h1;
  localparam logic [3:0] ALU_SHR = 4'h7;
  localparam logic [1:0] CMP_EQ = 2'b00;
  typedef enum logic [2:0] {IDLE, ADD, SHR_HI, SHR_LO, DONE} mul_state_t;
endpackage

// File: rtl/alu_mul_seq_if.sv
// alu_mul_seq_if: multiply request/result bus plus the pins to the dedicated ALU
interface alu_mul_seq_if;
  logic       start;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       busy;
  logic       done;
  logic [7:0] prod_hi;
  logic [7:0] prod_lo;
  logic [7:0] alu_in_a;
  logic [7:0] alu_in_b;
  logic [3:0] alu_op;
  logic       alu_carry_in;
  logic [1:0] alu_cmp_type;
  logic [7:0] alu_result;
  logic       alu_carry;
  modport slave (
    input  start, op_a, op_b, alu_result, alu_carry,
    output busy, done, prod_hi, prod_lo, alu_in_a, alu_in_b, alu_op, alu_carry_in, alu_cmp_type
  );
  modport master (
    output start, op_a, op_b, alu_result, alu_carry,
    input  busy, done, prod_hi, prod_lo, alu_in_a, alu_in_b, alu_op, alu_carry_in, alu_cmp_type
  );
endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: 8x8 unsigned shift-add multiplier sequencing an external ALU
module alu_mul_seq
  import alu_mul_seq_pkg::*;
#(
  parameter int N_ITER = 8
) (
  input logic          i_clk,
  input logic          i_rst,
  alu_mul_seq_if.slave bus
);
  mul_state_t r_state;
  logic [7:0] r_m, r_hi, r_lo, r_prod_hi, r_prod_lo;
  logic       r_c, r_busy, r_done;
  logic [2:0] r_cnt;
  logic       w_shr;
  assign w_shr = r_state == SHR_HI || r_state == SHR_LO;
  // C carries the add's 9th bit into the Hi shift, then Hi's LSB into the Lo shift
  assign bus.alu_op       = r_state == ADD ? ALU_ADD : w_shr ? ALU_SHR : ALU_NOP;
  assign bus.alu_in_a     = (r_state == ADD || r_state == SHR_HI) ? r_hi : r_state == SHR_LO ? r_lo : 8'h00;
  assign bus.alu_in_b     = (r_state == ADD && r_lo[0]) ? r_m : 8'h00;
  assign bus.alu_carry_in = w_shr ? r_c : 1'b0;
  assign bus.alu_cmp_type = CMP_EQ;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.prod_hi      = r_prod_hi;
  assign bus.prod_lo      = r_prod_lo;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_m       <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_c       <= 1'b0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_prod_hi <= '0;
      r_prod_lo <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.start) begin
          r_m     <= bus.op_a;
          r_hi    <= '0;
          r_lo    <= bus.op_b;
          r_c     <= 1'b0;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
          r_state <= ADD;
        end
        ADD: begin
          r_hi    <= bus.alu_result;
          r_c     <= bus.alu_carry;
          r_state <= SHR_HI;
        end
        SHR_HI: begin
          r_hi    <= bus.alu_result;
          r_c     <= bus.alu_carry;
          r_state <= SHR_LO;
        end
        SHR_LO: begin
          r_lo <= bus.alu_result;
          r_c  <= 1'b0;
          if (r_cnt == 3'(N_ITER - 1)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt   <= r_cnt + 3'd1;
            r_state <= ADD;
          end
        end
        DONE: begin
          r_prod_hi <= r_hi;
          r_prod_lo <= r_lo;
          r_done    <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: randomized and directed checks of the multiplier against a*b
module tb_alu_mul_seq;
  import alu_mul_seq_pkg::*;
  localparam int N = 8;
  localparam int LAT = 3 * N + 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  bit last_cy, last_bnz;
  alu_mul_seq_if bus ();
  alu_mul_seq #(.N_ITER(N)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // behavioural ALU: add with carry, or shift right pulling carry-in into the MSB
  always_comb begin
    {bus.alu_carry, bus.alu_result} = 9'h000;
    if (bus.alu_op == ALU_ADD)
      {bus.alu_carry, bus.alu_result} = {1'b0, bus.alu_in_a} + {1'b0, bus.alu_in_b} + {8'h00, bus.alu_carry_in};
    else if (bus.alu_op == ALU_SHR)
      {bus.alu_carry, bus.alu_result} = {bus.alu_in_a[0], bus.alu_carry_in, bus.alu_in_a[7:1]};
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic mul(input logic [7:0] a, input logic [7:0] b, input bit noise, input string tag);
    int lat, nb;
    bus.op_a = a;
    bus.op_b = b;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    lat = 1;
    nb = 0;
    last_cy = 1'b0;
    last_bnz = 1'b0;
    while (!bus.done && lat < 100) begin
      if (bus.busy) nb++;
      if (bus.alu_op == ALU_ADD) begin
        last_cy |= bus.alu_carry;
        last_bnz |= bus.alu_in_b != 8'h00;
      end
      bus.start = noise && bus.busy && $urandom_range(0, 1) == 1;
      if (bus.start) begin
        bus.op_a = 8'($urandom);
        bus.op_b = 8'($urandom);
      end
      step();
      lat++;
    end
    bus.start = 1'b0;
    chk({tag, " done latency"}, lat, LAT);
    chk({tag, " busy cycles"}, nb, LAT - 1);
    step();
    chk({tag, " product"}, {bus.prod_hi, bus.prod_lo}, 16'(a) * 16'(b));
    chk({tag, " idle after done"}, {bus.busy, bus.done}, 0);
  endtask
  initial begin
    int nd, t1, t2, lat;
    bit pd;
    bus.start = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    step();
    step();
    chk("reset busy/done", {bus.busy, bus.done}, 0);
    chk("reset product", {bus.prod_hi, bus.prod_lo}, 0);
    chk("reset alu op", bus.alu_op, ALU_NOP);
    chk("cmp type", bus.alu_cmp_type, CMP_EQ);
    rst = 1'b0;
    step();
    mul(8'd13, 8'd11, 1'b0, "13x11");
    mul(8'd255, 8'd255, 1'b0, "255x255");
    chk("255x255 add carry seen", last_cy, 1);
    mul(8'd0, 8'd200, 1'b0, "0x200");
    mul(8'd200, 8'd0, 1'b0, "200x0");
    chk("200x0 add operand b zero", last_bnz, 0);
    bus.op_a = 8'h05;
    bus.op_b = 8'h01;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("trace1 op", bus.alu_op, ALU_ADD);
    chk("trace1 a", bus.alu_in_a, 0);
    chk("trace1 b", bus.alu_in_b, 5);
    step();
    chk("trace2 op", bus.alu_op, ALU_SHR);
    chk("trace2 a", bus.alu_in_a, 5);
    chk("trace2 cin", bus.alu_carry_in, 0);
    step();
    chk("trace3 op", bus.alu_op, ALU_SHR);
    chk("trace3 a", bus.alu_in_a, 1);
    chk("trace3 cin", bus.alu_carry_in, 1);
    lat = 3;
    while (!bus.done && lat < 100) begin
      step();
      lat++;
    end
    chk("trace done latency", lat, LAT);
    step();
    chk("trace product", {bus.prod_hi, bus.prod_lo}, 16'h0005);
    bus.op_a = 8'd20;
    bus.op_b = 8'd3;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (9) step();
    rst = 1'b1;
    bus.start = 1'b1;
    step();
    rst = 1'b0;
    bus.start = 1'b0;
    chk("midreset busy/done", {bus.busy, bus.done}, 0);
    chk("midreset product", {bus.prod_hi, bus.prod_lo}, 0);
    chk("midreset alu op", bus.alu_op, ALU_NOP);
    mul(8'd7, 8'd9, 1'b1, "7x9 noisy");
    for (int i = 0; i < 6; i++) mul(8'($urandom), 8'($urandom), 1'b1, "random");
    nd = 0;
    t1 = 0;
    t2 = 0;
    pd = 1'b0;
    bus.op_a = 8'd2;
    bus.op_b = 8'd3;
    bus.start = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (pd) chk("held product", {bus.prod_hi, bus.prod_lo}, 16'h0006);
      pd = bus.done;
      if (bus.done) begin
        nd++;
        if (nd == 1) t1 = i;
        else t2 = i;
      end
    end
    bus.start = 1'b0;
    chk("held done count", nd, 2);
    chk("held first done", t1, LAT);
    chk("held done spacing", t2 - t1, LAT + 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle 8x8 unsigned shift-add multiplier controller.
- Acts as the initiator on the ALU interface. It drives operand A, operand B, opcode, carry-in and comparison type into a dedicated ALU instance, then consumes the ALU result and carry-out.
- Sits beside the datapath ALU. The control unit uses it to implement the multiply macro-operation and receives a 16-bit product.

Parameters:
- N_ITER, 8, number of multiplier bits processed. Legal range 1..8.

Ports:
- Clk  input  1  system clock
- Reset  input  1  synchronous, active-high reset
- Start  input  1  request a multiply; sampled only in IDLE
- OpA  input  8  multiplicand
- OpB  input  8  multiplier
- Busy  output  1  high while iterating
- Done  output  1  one-cycle pulse; product valid
- ProdHi  output  8  product bits [15:8]
- ProdLo  output  8  product bits [7:0]
- AluInA  output  8  to ALU InputA
- AluInB  output  8  to ALU InputB
- AluOpOut  output  4  to ALU AluOp
- AluCarryIn  output  1  to ALU CarryIn
- AluCmpType  output  2  to ALU ComparisonType; always CMP_EQ
- AluResult  input  8  from ALU AluOut
- AluCarry  input  1  from ALU CarryOut

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high.
- Reset values:
  - State=IDLE.
  - Busy=0, Done=0.
  - ProdHi=0, ProdLo=0.
  - Internal M, Hi, Lo, C and count = 0.
- Reset mid-operation: state returns to IDLE at that edge and the partial product is discarded (ProdHi/ProdLo=0).
- Registers: M (8), Hi (8), Lo (8), C (1), count (3 bits, wide enough for N_ITER).
- IDLE:
  - ALU pins driven to ALU_NOP, A=B=0, CarryIn=0.
  - On an edge with Start=1: M<=OpA, Hi<=0, Lo<=OpB, C<=0, count<=0, go to ADD.
  - OpA and OpB are ignored after capture.
- ADD:
  - AluOpOut=ALU_ADD, AluInA=Hi, AluInB = Lo[0] ? M : 8'h00, AluCarryIn=0.
  - Edge: Hi<=AluResult, C<=AluCarry, go to SHR_HI.
  - The ADD cycle is always issued, so timing is data-independent.
- SHR_HI:
  - ALU_SHR, AluInA=Hi, AluCarryIn=C.
  - Edge: Hi<=AluResult ({C,Hi[7:1]}), C<=AluCarry (old Hi[0]), go to SHR_LO.
- SHR_LO:
  - ALU_SHR, AluInA=Lo, AluCarryIn=C.
  - Edge: Lo<=AluResult, C<=0.
  - If count==N_ITER-1, go to DONE; otherwise count<=count+1 and go to ADD.
- DONE:
  - ALU pins driven to NOP. Done=1 for exactly this cycle.
  - Edge: ProdHi<=Hi, ProdLo<=Lo, go to IDLE.
  - ProdHi/ProdLo become valid in the IDLE cycle that follows DONE.
  - Alternatively ProdHi/ProdLo may be driven combinationally from Hi/Lo in DONE. Fix one choice at implementation; the bench checks in the cycle after the Done pulse.
- Busy = 1 in ADD, SHR_HI and SHR_LO; 0 otherwise.
- Latency: Start sampled at edge k.
  - Busy is high for cycles k+1 .. k+3*N_ITER.
  - Done is high in cycle k+3*N_ITER+1; that is k+25 for N_ITER=8.
  - The product is stable from cycle k+3*N_ITER+2 until the next accepted Start.
- Start while Busy or in DONE: ignored, with no queuing. A Start held high continuously produces back-to-back multiplies, each accepted in IDLE.
- Product holding: ProdHi/ProdLo hold their last value until the next DONE. They are not cleared on Start.
- Arithmetic: all values unsigned. The 9-bit add carry is propagated through C, so no overflow is lost and the product is exact in 16 bits.

Decomposition:
- definitions package:
  - typedef enum mul_state_t {IDLE, ADD, SHR_HI, SHR_LO, DONE}.
  - Reuse the existing ALU_ADD, ALU_SHR, ALU_NOP and CMP_EQ constants. No new opcode is added.
- No internal sub-module. The ALU is instantiated alongside this block by the parent (or bench) and wired to the Alu* ports.

Test Plan:
- OpA=13, OpB=11, Start pulse at edge k -> Done at k+25; then {ProdHi,ProdLo}=16'h008F. Busy high for exactly 24 cycles.
- OpA=255, OpB=255 -> product 16'hFE01. Carry into Hi observed (AluCarry=1) in at least one ADD cycle.
- OpA=0, OpB=200, and separately OpA=200, OpB=0 -> product 16'h0000. Every ADD cycle drives AluInB=0 in the OpB=0 case.
- Cycle-level trace, OpA=8'h05, OpB=8'h01 -> cycle k+1: ALU_ADD, AluInA=0, AluInB=5. Cycle k+2: ALU_SHR, AluInA=5, AluCarryIn=0. Cycle k+3: ALU_SHR, AluInA=1, AluCarryIn=1. Final product 16'h0005.
- Start 20x3, then at cycle k+10 assert Reset for one cycle and pulse Start again with pulses also during Busy -> at reset: Busy=0, Done=0, Prod=0, state IDLE. Starts during Busy are ignored. The next IDLE Start with 7x9 yields 16'h003F exactly 25 cycles later.
- Start held high for 60 cycles with OpA=2, OpB=3 -> two Done pulses, 26 cycles apart, each with product 16'h0006.
